// File: rtl/pc_pkg.sv
// Shared definitions for the LEGv8 fetch-stage program counter: FSM state
// encoding and the default parameter values used by pc_sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_BOOT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } pc_state_t;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_INC    = 4;
  localparam int DEF_OFS_W  = 26;

endpackage

// File: rtl/pc_adder.sv
// Plain modulo-2**W adder, used for both the sequential increment and the
// PC-relative branch target.
module pc_adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] sum
);

  assign sum = a_in + b_in;

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with next-PC selection (increment, PC-relative
// and register branches, stall) and a RESET/BOOT/RUN/HALT sequencing FSM.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               ADDR_W    = DEF_ADDR_W,
  parameter int               INC       = DEF_INC,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int               OFS_W     = DEF_OFS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_base,
  input  logic [OFS_W-1:0]  br_offset,
  input  logic              br_reg,
  input  logic [ADDR_W-1:0] br_reg_tgt,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_inc,
  output logic              pc_valid,
  output logic              align_err,
  output logic [1:0]        state
);

  localparam logic [ADDR_W-1:0] INC_VAL = ADDR_W'(INC);

  pc_state_t         cur_state;
  logic [ADDR_W-1:0] br_ofs_bytes;
  logic [ADDR_W-1:0] br_target;

  // Word offset sign-extended to full PC width, then scaled to bytes.
  assign br_ofs_bytes = {{(ADDR_W-OFS_W){br_offset[OFS_W-1]}}, br_offset} << 2;

  pc_adder #(.W(ADDR_W)) u_inc_adder (
    .a_in (pc),
    .b_in (INC_VAL),
    .sum  (pc_plus_inc)
  );

  pc_adder #(.W(ADDR_W)) u_br_adder (
    .a_in (br_base),
    .b_in (br_ofs_bytes),
    .sum  (br_target)
  );

  assign state = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_RESET;
      pc        <= RESET_VEC;
      pc_valid  <= 1'b0;
      align_err <= 1'b0;
    end else begin
      case (cur_state)
        ST_RESET: begin
          cur_state <= ST_BOOT;
          pc        <= RESET_VEC;
          pc_valid  <= 1'b1;
        end
        // BOOT fetches RESET_VEC once, then sequential fetch begins.
        ST_BOOT: begin
          cur_state <= ST_RUN;
          pc        <= pc_plus_inc;
          pc_valid  <= 1'b1;
        end
        ST_RUN: begin
          if (halt_req) begin
            cur_state <= ST_HALT;
            pc_valid  <= 1'b0;
          end else if (br_reg) begin
            pc        <= {br_reg_tgt[ADDR_W-1:2], 2'b00};
            align_err <= |br_reg_tgt[1:0];
          end else if (br_taken) begin
            pc        <= br_target;
            align_err <= 1'b0;
          end else if (!stall) begin
            pc        <= pc_plus_inc;
          end
        end
        ST_HALT: begin
          if (resume && !halt_req) begin
            cur_state <= ST_RUN;
            pc_valid  <= 1'b1;
          end
        end
        default: begin
          cur_state <= ST_RESET;
          pc        <= RESET_VEC;
          pc_valid  <= 1'b0;
          align_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run, all compared against a behavioural PC model kept in the bench.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_taken, br_reg, halt_req, resume;
  logic [63:0] br_base, br_reg_tgt;
  logic [25:0] br_offset;
  logic [63:0] pc, pc_plus_inc;
  logic        pc_valid, align_err;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0=RESET 1=BOOT 2=RUN 3=HALT
  logic [1:0]  m_phase;
  logic [63:0] m_pc;
  logic        m_align;

  logic [131:0] obs;
  assign obs = {state, pc_valid, align_err, pc, pc_plus_inc};

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_base(br_base), .br_offset(br_offset), .br_reg(br_reg),
    .br_reg_tgt(br_reg_tgt), .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_plus_inc(pc_plus_inc), .pc_valid(pc_valid),
    .align_err(align_err), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [131:0] expected();
    logic valid;
    valid = (m_phase == 2'd1) || (m_phase == 2'd2);
    return {m_phase, valid, m_align, m_pc, m_pc + 64'd4};
  endfunction

  task automatic model_reset();
    m_phase = 2'd0;
    m_pc    = 64'd0;
    m_align = 1'b0;
  endtask

  task automatic model_edge();
    longint ofs;
    case (m_phase)
      2'd0: begin m_phase = 2'd1; m_pc = 64'd0; end
      2'd1: begin m_phase = 2'd2; m_pc = m_pc + 64'd4; end
      2'd2: begin
        if (halt_req) m_phase = 2'd3;
        else if (br_reg) begin
          m_pc    = br_reg_tgt & ~64'd3;
          m_align = (br_reg_tgt % 4) != 0;
        end else if (br_taken) begin
          ofs     = longint'($signed(br_offset));
          m_pc    = br_base + ofs * 4;
          m_align = 1'b0;
        end else if (!stall) m_pc = m_pc + 64'd4;
      end
      default: if (resume && !halt_req) m_phase = 2'd2;
    endcase
  endtask

  task automatic clear_inputs();
    stall = 0; br_taken = 0; br_reg = 0; halt_req = 0; resume = 0;
    br_base = '0; br_offset = '0; br_reg_tgt = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs !== expected()) begin
      miscompares++;
      $display("[TB] FAIL reset_state got %h want %h", obs, expected());
    end
    rst_n = 1;
    #1;
    vectors++;
    if (pc !== 64'd0 || pc_valid !== 1'b0 || state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_cycle0 got pc=%h valid=%b state=%0d want pc=0 valid=0 state=0", pc, pc_valid, state);
    end
    step();
    vectors++;
    if (pc !== 64'd0 || pc_valid !== 1'b1 || state !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL boot got pc=%h valid=%b state=%0d want pc=0 valid=1 state=1", pc, pc_valid, state);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++;
      if (pc !== 64'(4 * i) || obs !== expected()) begin
        miscompares++;
        $display("[TB] FAIL run_seq%0d got %h want %h", i, obs, expected());
      end
    end
  endtask

  task automatic test_stall();
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (pc !== 64'h10 || obs !== expected()) begin
        miscompares++;
        $display("[TB] FAIL stall_hold%0d got pc=%h want pc=10", i, pc);
      end
    end
    stall = 0;
    step();
    vectors++;
    if (pc !== 64'h14 || obs !== expected()) begin
      miscompares++;
      $display("[TB] FAIL stall_release got pc=%h want pc=14", pc);
    end
  endtask

  task automatic test_branch();
    br_taken = 1; br_base = 64'h40; br_offset = 26'h3FFFFFE;
    step();
    vectors++;
    if (pc !== 64'h38 || obs !== expected()) begin
      miscompares++;
      $display("[TB] FAIL br_neg got pc=%h want pc=38", pc);
    end
    stall = 1;
    step();
    vectors++;
    if (pc !== 64'h38 || obs !== expected()) begin
      miscompares++;
      $display("[TB] FAIL br_over_stall got pc=%h want pc=38", pc);
    end
    clear_inputs();
  endtask

  task automatic test_reg_branch();
    br_reg = 1; br_reg_tgt = 64'h1003; br_taken = 1; br_base = 64'h200; br_offset = 26'd8;
    step();
    vectors++;
    if (pc !== 64'h1000 || align_err !== 1'b1 || obs !== expected()) begin
      miscompares++;
      $display("[TB] FAIL br_reg_wins got pc=%h align=%b want pc=1000 align=1", pc, align_err);
    end
    clear_inputs();
    step();
    vectors++;
    if (pc !== 64'h1004 || align_err !== 1'b1 || obs !== expected()) begin
      miscompares++;
      $display("[TB] FAIL align_sticky got pc=%h align=%b want pc=1004 align=1", pc, align_err);
    end
    br_taken = 1; br_base = 64'h40; br_offset = 26'd1;
    step();
    vectors++;
    if (pc !== 64'h44 || align_err !== 1'b0 || obs !== expected()) begin
      miscompares++;
      $display("[TB] FAIL align_clear got pc=%h align=%b want pc=44 align=0", pc, align_err);
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    br_reg = 1; br_reg_tgt = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    clear_inputs();
    vectors++;
    if (pc_plus_inc !== 64'd0 || obs !== expected()) begin
      miscompares++;
      $display("[TB] FAIL wrap_plus_inc got %h want 0", pc_plus_inc);
    end
    step();
    vectors++;
    if (pc !== 64'd0 || obs !== expected()) begin
      miscompares++;
      $display("[TB] FAIL wrap_pc got %h want 0", pc);
    end
  endtask

  task automatic test_halt();
    halt_req = 1;
    step();
    vectors++;
    if (pc !== 64'd0 || pc_valid !== 1'b0 || state !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL halt_enter got pc=%h valid=%b state=%0d want pc=0 valid=0 state=3", pc, pc_valid, state);
    end
    halt_req = 0; br_reg = 1; br_reg_tgt = 64'h500; br_taken = 1; stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (obs !== expected()) begin
        miscompares++;
        $display("[TB] FAIL halt_ignore%0d got %h want %h", i, obs, expected());
      end
    end
    clear_inputs();
    resume = 1; halt_req = 1;
    step();
    vectors++;
    if (state !== 2'd3 || obs !== expected()) begin
      miscompares++;
      $display("[TB] FAIL halt_resume_conflict got state=%0d want state=3", state);
    end
    halt_req = 0;
    step();
    resume = 0;
    vectors++;
    if (state !== 2'd2 || pc_valid !== 1'b1 || obs !== expected()) begin
      miscompares++;
      $display("[TB] FAIL resume got %h want %h", obs, expected());
    end
    step();
    vectors++;
    if (pc !== 64'd4 || obs !== expected()) begin
      miscompares++;
      $display("[TB] FAIL resume_inc got pc=%h want pc=4", pc);
    end
  endtask

  task automatic test_async_reset();
    br_reg = 1; br_reg_tgt = 64'h84;
    step();
    clear_inputs();
    step();
    #3;
    rst_n = 0;
    model_reset();
    #1;
    vectors++;
    if (pc !== 64'd0 || pc_valid !== 1'b0 || state !== 2'd0 || obs !== expected()) begin
      miscompares++;
      $display("[TB] FAIL async_reset got pc=%h valid=%b state=%0d want pc=0 valid=0 state=0", pc, pc_valid, state);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (obs !== expected()) begin
        miscompares++;
        $display("[TB] FAIL reboot%0d got %h want %h", i, obs, expected());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      halt_req   = ($urandom_range(0, 19) == 0);
      resume     = ($urandom_range(0, 2) == 0);
      br_reg     = ($urandom_range(0, 9) == 0);
      br_taken   = ($urandom_range(0, 6) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      br_base    = {$urandom, $urandom};
      br_offset  = 26'($urandom);
      br_reg_tgt = {$urandom, $urandom};
      step();
      vectors++;
      if (obs !== expected()) begin
        miscompares++;
        $display("[TB] FAIL random%0d got %h want %h", i, obs, expected());
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_reg_branch();
    test_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
